// File: rtl/jtdd_mcu_com_if.sv
// Main-CPU / MCU link bus: CPU register and shared-RAM window signals plus MCU control lines.
// The CPU side drives through master; the controller sits on slave.
interface jtdd_mcu_com_if;
    logic       cen;
    logic       ctrl_cs;
    logic       com_cs;
    logic [1:0] cpu_addr;
    logic       cpu_wrn;
    logic [7:0] cpu_dout;
    logic [7:0] status_dout;
    logic       cpu_waitn;
    logic       main_irq;
    logic       mcu_halt;
    logic       mcu_nmi_set;
    logic       mcu_ban;
    logic       mcu_irqmain;

    modport master (
        output cen, ctrl_cs, com_cs, cpu_addr, cpu_wrn, cpu_dout, mcu_ban, mcu_irqmain,
        input  status_dout, cpu_waitn, main_irq, mcu_halt, mcu_nmi_set
    );

    modport slave (
        input  cen, ctrl_cs, com_cs, cpu_addr, cpu_wrn, cpu_dout, mcu_ban, mcu_irqmain,
        output status_dout, cpu_waitn, main_irq, mcu_halt, mcu_nmi_set
    );
endinterface

// File: rtl/jtdd_mcu_com.sv
// Main-CPU side of the MCU link: halt/NMI control, shared-RAM arbitration against
// MCU bus activity, MCU-to-main interrupt latch and status register.
module jtdd_mcu_com #(
    parameter int SETTLE  = 2,
    parameter int TIMEOUT = 1023,
    parameter int NMI_LEN = 4
) (
    input  logic         clk,
    input  logic         rstn,
    jtdd_mcu_com_if.slave bus
);
    localparam int SW = $clog2(SETTLE + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int NW = $clog2(NMI_LEN + 1);

    typedef enum logic [1:0] {IDLE, REQ, GRANT, RELEASE} state_t;

    state_t        state_reg, state_next;
    logic          sw_halt_reg;
    logic          err_reg;
    logic          irq_reg;
    logic          irq_last_reg;
    logic          wr_last_reg;
    logic [SW-1:0] settle_cnt_reg;
    logic [TW-1:0] req_cnt_reg;
    logic [NW-1:0] nmi_cnt_reg;

    logic wr_act, wr_stb, settled, timeout_hit, irq_edge, granted;

    // One write per CPU access: edge of the write strobe as seen on cen cycles.
    assign wr_act      = bus.ctrl_cs & ~bus.cpu_wrn;
    assign wr_stb      = bus.cen & wr_act & ~wr_last_reg;
    // settle_cnt holds the low run before this cycle, so this cycle completes SETTLE.
    assign settled     = ~bus.mcu_ban & (settle_cnt_reg >= SW'(SETTLE - 1));
    assign timeout_hit = (req_cnt_reg == TW'(TIMEOUT - 1));
    assign irq_edge    = bus.mcu_irqmain & ~irq_last_reg;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (sw_halt_reg && settled) begin
                    state_next = GRANT;
                end else if (bus.com_cs) begin
                    state_next = REQ;
                end
            end
            REQ: begin
                if (!bus.com_cs) begin
                    state_next = IDLE;
                end else if (settled || timeout_hit) begin
                    state_next = GRANT;
                end
            end
            // A software-halted MCU keeps the RAM parked on the main side.
            GRANT: begin
                if (!bus.com_cs && !sw_halt_reg) begin
                    state_next = RELEASE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        granted         = (state_reg == GRANT);
        bus.mcu_halt    = sw_halt_reg | (state_reg == REQ) | (state_reg == GRANT);
        // Held high while in reset so the CPU is never stalled by a dead controller.
        bus.cpu_waitn   = ~(rstn & bus.com_cs & ~granted);
        bus.main_irq    = irq_reg;
        bus.mcu_nmi_set = (nmi_cnt_reg != '0);
        bus.status_dout = {4'b0000, err_reg, irq_reg, granted, bus.mcu_ban};
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sw_halt_reg    <= 1'b0;
            err_reg        <= 1'b0;
            irq_reg        <= 1'b0;
            irq_last_reg   <= 1'b0;
            wr_last_reg    <= 1'b0;
            settle_cnt_reg <= '0;
            req_cnt_reg    <= '0;
            nmi_cnt_reg    <= '0;
        end else begin
            if (bus.cen) begin
                wr_last_reg <= wr_act;
            end
            if (wr_stb && bus.cpu_addr == 2'd0) begin
                sw_halt_reg <= bus.cpu_dout[0];
            end

            if (bus.mcu_ban) begin
                settle_cnt_reg <= '0;
            end else if (settle_cnt_reg != SW'(SETTLE)) begin
                settle_cnt_reg <= settle_cnt_reg + 1'b1;
            end

            if (state_reg == REQ && state_next == REQ) begin
                req_cnt_reg <= req_cnt_reg + 1'b1;
            end else begin
                req_cnt_reg <= '0;
            end

            // Set beats clear for both sticky flags.
            if (state_reg == REQ && bus.com_cs && timeout_hit && !settled) begin
                err_reg <= 1'b1;
            end else if (wr_stb && bus.cpu_addr == 2'd2) begin
                err_reg <= 1'b0;
            end

            irq_last_reg <= bus.mcu_irqmain;
            if (irq_edge) begin
                irq_reg <= 1'b1;
            end else if (wr_stb && bus.cpu_addr == 2'd2) begin
                irq_reg <= 1'b0;
            end

            if (wr_stb && bus.cpu_addr == 2'd1) begin
                nmi_cnt_reg <= NW'(NMI_LEN);
            end else if (nmi_cnt_reg != '0) begin
                nmi_cnt_reg <= nmi_cnt_reg - 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_jtdd_mcu_com.sv
// Bench for jtdd_mcu_com: vector table, hand-written corner sequences and a
// randomized run against a cycle-level behavioural model.
module tb_jtdd_mcu_com;
    localparam int SETTLE  = 2;
    localparam int TIMEOUT = 1023;
    localparam int NMI_LEN = 4;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    int   checks = 0;
    int   failures = 0;

    jtdd_mcu_com_if bus_if ();

    jtdd_mcu_com #(.SETTLE(SETTLE), .TIMEOUT(TIMEOUT), .NMI_LEN(NMI_LEN)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus_if)
    );

    always #5 clk = ~clk;

    // Behavioural model: phase flags plus plain counters of cycles.
    bit m_sw_halt, m_err, m_irq, m_irq_prev, m_wr_prev, m_granted, m_release;
    int m_req, m_low_run, m_nmi_left;

    task automatic model_reset();
        m_sw_halt = 0; m_err = 0; m_irq = 0; m_irq_prev = 0; m_wr_prev = 0;
        m_granted = 0; m_release = 0; m_req = -1; m_low_run = 0; m_nmi_left = 0;
    endtask

    task automatic model_update();
        bit wr, settled, tmo;
        wr  = bus_if.cen && bus_if.ctrl_cs && !bus_if.cpu_wrn && !m_wr_prev;
        tmo = 0;
        if (bus_if.cen) m_wr_prev = bus_if.ctrl_cs && !bus_if.cpu_wrn;
        m_low_run = bus_if.mcu_ban ? 0 : ((m_low_run < 1000) ? m_low_run + 1 : m_low_run);
        settled = (m_low_run >= SETTLE);
        if (m_granted) begin
            if (!bus_if.com_cs && !m_sw_halt) begin m_granted = 0; m_release = 1; end
        end else if (m_release) begin
            m_release = 0;
        end else if (m_req >= 0) begin
            if (!bus_if.com_cs) m_req = -1;
            else if (settled) begin m_granted = 1; m_req = -1; end
            else if (m_req + 1 >= TIMEOUT) begin m_granted = 1; m_req = -1; tmo = 1; end
            else m_req++;
        end else if (m_sw_halt && settled) begin
            m_granted = 1;
        end else if (bus_if.com_cs) begin
            m_req = 0;
        end
        if (wr && bus_if.cpu_addr == 2'd0) m_sw_halt = bus_if.cpu_dout[0];
        if (wr && bus_if.cpu_addr == 2'd2) begin m_irq = 0; m_err = 0; end
        if (tmo) m_err = 1;
        if (bus_if.mcu_irqmain && !m_irq_prev) m_irq = 1;
        m_irq_prev = bus_if.mcu_irqmain;
        if (wr && bus_if.cpu_addr == 2'd1) m_nmi_left = NMI_LEN;
        else if (m_nmi_left > 0) m_nmi_left--;
    endtask

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            if (failures <= 40)
                $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic check_model();
        chk("model_status", {8'h00, bus_if.status_dout},
            {8'h00, 4'b0000, m_err, m_irq, m_granted, bus_if.mcu_ban});
        chk("model_waitn", {15'd0, bus_if.cpu_waitn}, {15'd0, !(bus_if.com_cs && !m_granted)});
        chk("model_halt", {15'd0, bus_if.mcu_halt}, {15'd0, m_sw_halt || m_granted || (m_req >= 0)});
        chk("model_nmi", {15'd0, bus_if.mcu_nmi_set}, {15'd0, m_nmi_left > 0});
        chk("model_irq", {15'd0, bus_if.main_irq}, {15'd0, m_irq});
    endtask

    task automatic tick();
        @(posedge clk);
        if (rstn) model_update();
        #1;
    endtask

    task automatic step();
        tick();
        check_model();
    endtask

    task automatic idle_inputs();
        bus_if.cen = 1; bus_if.ctrl_cs = 0; bus_if.cpu_wrn = 1; bus_if.cpu_addr = 0;
        bus_if.cpu_dout = 0; bus_if.com_cs = 0; bus_if.mcu_ban = 1; bus_if.mcu_irqmain = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rstn = 0;
        model_reset();
        @(posedge clk); @(posedge clk); #1;
        rstn = 1;
    endtask

    typedef struct {
        logic       ctrl, wrn;
        logic [1:0] addr;
        logic [7:0] dout;
        logic       com, ban, irqm;
        logic [7:0] st;
        logic       waitn, halt, nmi;
    } vec_t;

    function automatic vec_t mk(logic ctrl, logic wrn, logic [1:0] addr, logic com, logic ban,
                                logic irqm, logic [7:0] st, logic waitn, logic halt, logic nmi);
        vec_t v;
        v.ctrl = ctrl; v.wrn = wrn; v.addr = addr; v.dout = 8'h00; v.com = com; v.ban = ban;
        v.irqm = irqm; v.st = st; v.waitn = waitn; v.halt = halt; v.nmi = nmi;
        return v;
    endfunction

    vec_t tbl[14];

    initial begin
        int n;
        // Outputs expected after one clock with the row's inputs held.
        tbl[0]  = mk(0, 1, 2'd0, 0, 1, 0, 8'h01, 1, 0, 0);
        tbl[1]  = mk(0, 1, 2'd0, 0, 1, 1, 8'h05, 1, 0, 0);  // irq edge
        tbl[2]  = mk(1, 0, 2'd2, 0, 1, 1, 8'h01, 1, 0, 0);  // ack
        tbl[3]  = mk(1, 0, 2'd2, 0, 1, 0, 8'h01, 1, 0, 0);  // held strobe: no new write
        tbl[4]  = mk(0, 1, 2'd0, 0, 1, 1, 8'h05, 1, 0, 0);
        tbl[5]  = mk(0, 1, 2'd0, 0, 1, 0, 8'h05, 1, 0, 0);
        tbl[6]  = mk(1, 0, 2'd2, 0, 1, 1, 8'h05, 1, 0, 0);  // ack vs new edge: set wins
        tbl[7]  = mk(0, 1, 2'd0, 0, 1, 1, 8'h05, 1, 0, 0);
        tbl[8]  = mk(0, 1, 2'd0, 1, 1, 1, 8'h05, 0, 1, 0);  // REQ
        tbl[9]  = mk(0, 1, 2'd0, 1, 0, 1, 8'h04, 0, 1, 0);
        tbl[10] = mk(0, 1, 2'd0, 1, 0, 1, 8'h06, 1, 1, 0);  // GRANT
        tbl[11] = mk(0, 1, 2'd0, 0, 0, 1, 8'h04, 1, 0, 0);  // RELEASE
        tbl[12] = mk(1, 0, 2'd1, 0, 1, 1, 8'h05, 1, 0, 1);  // NMI write
        tbl[13] = mk(0, 1, 2'd0, 0, 1, 1, 8'h05, 1, 0, 1);

        do_reset();
        chk("reset_status", {8'h00, bus_if.status_dout}, 16'h0001);
        chk("reset_waitn", {15'd0, bus_if.cpu_waitn}, 16'd1);
        chk("reset_halt", {15'd0, bus_if.mcu_halt}, 16'd0);
        chk("reset_nmi", {15'd0, bus_if.mcu_nmi_set}, 16'd0);

        for (int i = 0; i < 14; i++) begin
            bus_if.ctrl_cs = tbl[i].ctrl; bus_if.cpu_wrn = tbl[i].wrn; bus_if.cpu_addr = tbl[i].addr;
            bus_if.cpu_dout = tbl[i].dout; bus_if.com_cs = tbl[i].com; bus_if.mcu_ban = tbl[i].ban;
            bus_if.mcu_irqmain = tbl[i].irqm;
            step();
            chk($sformatf("vec%0d_status", i), {8'h00, bus_if.status_dout}, {8'h00, tbl[i].st});
            chk($sformatf("vec%0d_waitn", i), {15'd0, bus_if.cpu_waitn}, {15'd0, tbl[i].waitn});
            chk($sformatf("vec%0d_halt", i), {15'd0, bus_if.mcu_halt}, {15'd0, tbl[i].halt});
            chk($sformatf("vec%0d_nmi", i), {15'd0, bus_if.mcu_nmi_set}, {15'd0, tbl[i].nmi});
            $display("vec %0d status=%02h waitn=%0b halt=%0b nmi=%0b", i, bus_if.status_dout,
                     bus_if.cpu_waitn, bus_if.mcu_halt, bus_if.mcu_nmi_set);
        end

        // Grant after mcu_ban drops at cycle 10; waitn drops with com_cs in the same cycle.
        do_reset();
        bus_if.com_cs = 1; bus_if.mcu_ban = 1; #1;
        chk("grant_waitn_c0", {15'd0, bus_if.cpu_waitn}, 16'd0);
        for (int c = 1; c <= 13; c++) begin
            tick();
            bus_if.mcu_ban = (c < 10);
            #1;
            check_model();
            chk($sformatf("grant_waitn_c%0d", c), {15'd0, bus_if.cpu_waitn}, {15'd0, c >= 12});
        end
        $display("grant sequence done status=%02h", bus_if.status_dout);

        // Forced grant after TIMEOUT cycles in REQ, then error clear.
        do_reset();
        bus_if.com_cs = 1; bus_if.mcu_ban = 1;
        for (int c = 1; c <= TIMEOUT + 1; c++) begin
            step();
            if (c == TIMEOUT) chk("timeout_pre", {8'h00, bus_if.status_dout}, 16'h0001);
        end
        chk("timeout_status", {8'h00, bus_if.status_dout}, 16'h000B);
        bus_if.ctrl_cs = 1; bus_if.cpu_wrn = 0; bus_if.cpu_addr = 2'd2;
        step();
        chk("timeout_err_clear", {8'h00, bus_if.status_dout}, 16'h0003);
        bus_if.ctrl_cs = 0; bus_if.cpu_wrn = 1; bus_if.com_cs = 0;
        step();
        $display("timeout sequence done status=%02h", bus_if.status_dout);

        // Single NMI pulse, then a rewrite on pulse cycle 2.
        do_reset();
        bus_if.ctrl_cs = 1; bus_if.cpu_wrn = 0; bus_if.cpu_addr = 2'd1;
        step();
        n = bus_if.mcu_nmi_set;
        bus_if.ctrl_cs = 0; bus_if.cpu_wrn = 1;
        for (int i = 0; i < 8; i++) begin step(); n += bus_if.mcu_nmi_set; end
        chk("nmi_len", n[15:0], 16'd4);
        bus_if.ctrl_cs = 1; bus_if.cpu_wrn = 0;
        step(); n = bus_if.mcu_nmi_set;
        bus_if.ctrl_cs = 0; bus_if.cpu_wrn = 1;
        step(); n += bus_if.mcu_nmi_set;
        bus_if.ctrl_cs = 1; bus_if.cpu_wrn = 0;
        step(); n += bus_if.mcu_nmi_set;
        bus_if.ctrl_cs = 0; bus_if.cpu_wrn = 1;
        for (int i = 0; i < 8; i++) begin step(); n += bus_if.mcu_nmi_set; end
        chk("nmi_restart_len", n[15:0], 16'd6);
        $display("nmi sequence done high_cycles=%0d", n);

        // Software halt with a quiet MCU bus: the CPU is never stalled.
        do_reset();
        bus_if.mcu_ban = 0; bus_if.ctrl_cs = 1; bus_if.cpu_wrn = 0; bus_if.cpu_addr = 2'd0;
        bus_if.cpu_dout = 8'h01;
        step();
        bus_if.ctrl_cs = 0; bus_if.cpu_wrn = 1;
        step(); step();
        bus_if.com_cs = 1; #1;
        chk("swhalt_waitn_c0", {15'd0, bus_if.cpu_waitn}, 16'd1);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("swhalt_waitn", {15'd0, bus_if.cpu_waitn}, 16'd1);
            chk("swhalt_halt", {15'd0, bus_if.mcu_halt}, 16'd1);
        end
        chk("swhalt_status", {8'h00, bus_if.status_dout}, 16'h0002);
        $display("sw_halt sequence done status=%02h", bus_if.status_dout);

        // Asynchronous reset while in GRANT with com_cs still asserted.
        #2; rstn = 0; #1;
        chk("rst_waitn", {15'd0, bus_if.cpu_waitn}, 16'd1);
        chk("rst_halt", {15'd0, bus_if.mcu_halt}, 16'd0);
        chk("rst_status", {8'h00, bus_if.status_dout}, 16'h0000);
        chk("rst_irq", {15'd0, bus_if.main_irq}, 16'd0);
        model_reset();
        @(posedge clk); #1;
        bus_if.com_cs = 0; rstn = 1;
        step();
        $display("reset sequence done status=%02h", bus_if.status_dout);

        // Randomized traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            bus_if.cen      = ($urandom_range(7) != 0);
            bus_if.ctrl_cs  = ($urandom_range(5) == 0);
            bus_if.cpu_wrn  = $urandom_range(1);
            bus_if.cpu_addr = 2'($urandom_range(3));
            bus_if.cpu_dout = 8'($urandom_range(255));
            if ($urandom_range(9) == 0) bus_if.com_cs = ~bus_if.com_cs;
            if ($urandom_range(3) == 0) bus_if.mcu_ban = ~bus_if.mcu_ban;
            if ($urandom_range(7) == 0) bus_if.mcu_irqmain = ~bus_if.mcu_irqmain;
            if (bus_if.ctrl_cs && !bus_if.cpu_wrn && bus_if.cen && !m_wr_prev)
                $display("rand write addr=%0d data=%02h cycle=%0d", bus_if.cpu_addr, bus_if.cpu_dout, i);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
